// File: rtl/gate_response_checker_if.sv
// Pattern-flow bundle between the gate checker and its environment.
// master: the checker (drives stimulus and status); slave: the environment.
// Optional first-fail fields exist only when GATE_CHK_FIRST_FAIL_EN is defined.
interface gate_response_checker_if #(
  parameter int N_IN = 3
);
  logic            start;
  logic            dut_f;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic            fail;
  logic [N_IN:0]   err_count;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic            first_fail_vld;
  logic [N_IN-1:0] first_fail_vec;
`endif

  modport master (
    input  start, dut_f,
`ifdef GATE_CHK_FIRST_FAIL_EN
    output first_fail_vld, first_fail_vec,
`endif
    output stim, busy, done, pass, fail, err_count
  );

  modport slave (
    output start, dut_f,
`ifdef GATE_CHK_FIRST_FAIL_EN
    input  first_fail_vld, first_fail_vec,
`endif
    input  stim, busy, done, pass, fail, err_count
  );
endinterface

// File: rtl/gate_response_checker.sv
// Walks every input vector of an N_IN-input gate, holds each HOLD_CYC cycles,
// compares the sampled gate output with TRUTH and reports pass/fail/err_count.
// Latency: 2**N_IN*HOLD_CYC RUN cycles; start is ignored while busy. Optional: GATE_CHK_FIRST_FAIL_EN.
module gate_response_checker #(
  parameter int                     N_IN     = 3,
  parameter logic [(1<<N_IN)-1:0]   TRUTH    = 8'b0000_0001,
  parameter int                     HOLD_CYC = 4
) (
  input logic                    clk,
  input logic                    rst,
  gate_response_checker_if.master bus
);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] idx;
  logic [HW-1:0]   hold;
  logic [N_IN:0]   err_q, err_nxt;
  logic            pass_q, fail_q;
  logic            start_acc, compare, last, mismatch;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic            ff_vld;
  logic [N_IN-1:0] ff_vec;
`endif

  // Decode of the current cycle: start acceptance and compare point.
  always_comb begin
    start_acc = bus.start && (state != RUN);
    compare   = (state == RUN) && (hold == HW'(HOLD_CYC - 1));
    last      = &idx;
    mismatch  = (bus.dut_f != TRUTH[idx]);
    err_nxt   = err_q;
    if (compare && mismatch) err_nxt = err_q + {{N_IN{1'b0}}, 1'b1};
  end

  // State register; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: start leaves IDLE/DONE, the last compare ends the run.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (compare && last) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Vector index, hold counter, mismatch count and verdict registers.
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      idx    <= '0;
      hold   <= '0;
      err_q  <= '0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      ff_vld <= 1'b0;
      ff_vec <= '0;
`endif
    end else if (state == RUN) begin
      if (compare) begin
        err_q <= err_nxt;
`ifdef GATE_CHK_FIRST_FAIL_EN
        if (mismatch && !ff_vld) begin
          ff_vld <= 1'b1;
          ff_vec <= idx;
        end
`endif
        hold <= '0;
        if (last) begin
          // Verdict is latched on the same edge that enters DONE.
          pass_q <= (err_nxt == '0);
          fail_q <= (err_nxt != '0);
        end else begin
          idx <= idx + {{(N_IN-1){1'b0}}, 1'b1};
        end
      end else begin
        hold <= hold + {{(HW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs: stim follows the index (holds last value in DONE), status from state.
  always_comb begin
    bus.stim      = idx;
    bus.busy      = (state == RUN);
    bus.done      = (state == DONE);
    bus.pass      = pass_q;
    bus.fail      = fail_q;
    bus.err_count = err_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
    bus.first_fail_vld = ff_vld;
    bus.first_fail_vec = ff_vec;
`endif
  end
endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker: behavioural gate models on dut_f,
// table of fault modes with hand-computed verdicts, plus reset/restart corners.
// A second instance with HOLD_CYC=1 covers the short-hold latency.
module tb_gate_response_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] mode;   // 0 ideal NOR, 1 stuck-0, 2 stuck-1, 3 OR
  int         checks = 0;
  int         errors = 0;

  gate_response_checker_if #(.N_IN(3)) bus ();
  gate_response_checker_if #(.N_IN(3)) bus1 ();

  function automatic logic gate_model(input logic [1:0] m, input logic [2:0] s);
    case (m)
      2'd0:    return ~|s;
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return |s;
    endcase
  endfunction

  assign bus.dut_f  = gate_model(mode, bus.stim);
  assign bus1.dut_f = ~|bus1.stim;

  gate_response_checker #(.N_IN(3), .TRUTH(8'b0000_0001), .HOLD_CYC(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gate_response_checker #(.N_IN(3), .TRUTH(8'b0000_0001), .HOLD_CYC(1)) u_dut_h1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stim"}, bus.stim, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_fail"}, bus.fail, 0);
    check({tag, "_err"},  bus.err_count, 0);
  endtask

  // Pulses start, then counts cycles until done (start cycle = cycle 0).
  task automatic run_main(input int extra_start_at, input bit chk_stim, output int done_cyc);
    int cyc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check("c1_busy", bus.busy, 1);
    check("c1_done", bus.done, 0);
    check("c1_pass", bus.pass, 0);
    check("c1_err",  bus.err_count, 0);
    while (!bus.done && cyc < 100) begin
      if (chk_stim) check("stim_walk", bus.stim, (cyc - 1) / 4);
      bus.start = (cyc == extra_start_at);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    if (!bus.done) check("done_timeout", 0, 1);
    done_cyc = cyc;
  endtask

  typedef struct {
    logic [1:0] mode;
    int         err;
    bit         pass;
    int         ff_vec;
    bit         ff_vld;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int dc;
    int c1;

    tbl[0] = '{mode: 2'd0, err: 0, pass: 1'b1, ff_vec: 0, ff_vld: 1'b0};
    tbl[1] = '{mode: 2'd1, err: 1, pass: 1'b0, ff_vec: 0, ff_vld: 1'b1};
    tbl[2] = '{mode: 2'd2, err: 7, pass: 1'b0, ff_vec: 1, ff_vld: 1'b1};
    tbl[3] = '{mode: 2'd3, err: 8, pass: 1'b0, ff_vec: 0, ff_vld: 1'b1};

    rst       = 1'b1;
    mode      = 2'd0;
    bus.start = 1'b0;
    bus1.start = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_rst");

    // Fault-mode table; each new run also starts from DONE of the previous one.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_main(0, (i == 0), dc);
      check("done_cycle", dc, 33);
      check("done",       bus.done, 1);
      check("busy_done",  bus.busy, 0);
      check("err_count",  bus.err_count, tbl[i].err);
      check("pass",       bus.pass, tbl[i].pass);
      check("fail",       bus.fail, !tbl[i].pass);
      check("stim_hold",  bus.stim, 7);
`ifdef GATE_CHK_FIRST_FAIL_EN
      check("ff_vld", bus.first_fail_vld, tbl[i].ff_vld);
      if (tbl[i].ff_vld) check("ff_vec", bus.first_fail_vec, tbl[i].ff_vec);
`endif
    end

    // start at cycle 5 of a run must be ignored.
    mode = 2'd0;
    run_main(5, 1'b0, dc);
    check("ign_done_cycle", dc, 33);
    check("ign_pass", bus.pass, 1);
    check("ign_err",  bus.err_count, 0);

    // Reset mid-run at cycle 10 while errors are already counted.
    mode = 2'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_rst_err", bus.err_count, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_rst");
    @(negedge clk);
    check("mid_rst_idle_busy", bus.busy, 0);
    mode = 2'd0;
    run_main(0, 1'b1, dc);
    check("clean_done_cycle", dc, 33);
    check("clean_pass", bus.pass, 1);
    check("clean_fail", bus.fail, 0);

    // HOLD_CYC=1 instance: eight RUN cycles, done in cycle 9.
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    c1 = 1;
    check("h1_busy", bus1.busy, 1);
    while (!bus1.done && c1 < 50) begin
      @(negedge clk);
      c1++;
    end
    check("h1_done_cycle", c1, 9);
    check("h1_pass", bus1.pass, 1);
    check("h1_err",  bus1.err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
